spi_master: RTL and testbench



---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_phase_timer.sv | 33 +++
 rtl/spi_master.sv | 141 ++++++++++++++
 tb/tb_spi_master.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the mode-0 SPI master: FSM states and limits.
package spi_pkg;

  localparam int SPI_MIN_CLK_DIV = 10;
  localparam int SPI_MAX_CLK_DIV = 255;
  localparam int SPI_BITS        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_TEARDOWN,
    ST_GAP
  } spi_state_e;

endpackage

// File: rtl/spi_phase_timer.sv
// Down-counter timing one SCLK half-period; reloads on every state entry.
module spi_phase_timer #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tc
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);

  logic [W-1:0] count;

  // Count down from CLK_DIV-1 after each load and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with <= only, so every flop samples
    // the pre-edge values of its inputs regardless of block ordering.
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  // NOTE: tc is a decode of the counter register, so it is high on the last
  // cycle of the phase and the FSM moves on at the following edge.
  assign tc = (count == '0);

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI mode-0 master (CPOL=0, CPHA=0, MSB first) with SS framing.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       hw_spi_clk,
  output logic       hw_spi_ss,
  output logic       hw_spi_mosi,
  input  logic       hw_spi_miso
);

  // NOTE: an out-of-range divider stops elaboration instead of silently
  // producing half-periods shorter than the receiver's stability filter.
  if (CLK_DIV < SPI_MIN_CLK_DIV || CLK_DIV > SPI_MAX_CLK_DIV) begin : g_bad_div
    $error("spi_master: CLK_DIV out of range 10..255");
  end

  localparam int BW = $clog2(SPI_BITS);

  spi_state_e          state;
  logic [SPI_BITS-2:0] tx_shift;   // bits still to be sent after the current one
  logic [SPI_BITS-2:0] rx_shift;   // bits received so far in this byte
  logic [BW-1:0]       bit_cnt;    // index of the bit currently on MOSI
  logic                last_q;
  logic [1:0]          miso_sync;
  logic                phase_done;
  logic                timed;
  logic                accept;
  logic                timer_load;
  logic [SPI_BITS-1:0] rx_next;

  assign timed      = (state != ST_IDLE) && (state != ST_HOLD);
  assign accept     = tx_valid && tx_ready;
  assign timer_load = accept || (timed && phase_done);
  assign rx_next    = {rx_shift, miso_sync[1]};

  spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_phase_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (timer_load),
    .tc   (phase_done)
  );

  // Two-flop synchroniser for the asynchronous MISO pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_sync <= '0;
    end else begin
      miso_sync <= {miso_sync[0], hw_spi_miso};
    end
  end

  // Transfer FSM with registered pin and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      last_q      <= 1'b0;
      tx_ready    <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      hw_spi_clk  <= 1'b0;
      hw_spi_ss   <= 1'b1;
      hw_spi_mosi <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            tx_shift    <= tx_data[SPI_BITS-2:0];
            last_q      <= tx_last;
            bit_cnt     <= BW'(SPI_BITS - 1);
            hw_spi_mosi <= tx_data[SPI_BITS-1];
            hw_spi_ss   <= 1'b0;
            tx_ready    <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_SETUP;
          end
        end
        ST_SETUP, ST_LOW: begin
          if (phase_done) begin
            hw_spi_clk <= 1'b1;
            state      <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (phase_done) begin
            hw_spi_clk <= 1'b0;
            rx_shift   <= rx_next[SPI_BITS-2:0];
            if (bit_cnt == '0) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
              if (last_q) begin
                hw_spi_mosi <= 1'b0;
                state       <= ST_TEARDOWN;
              end else begin
                tx_ready <= 1'b1;
                state    <= ST_HOLD;
              end
            end else begin
              bit_cnt     <= bit_cnt - BW'(1);
              hw_spi_mosi <= tx_shift[SPI_BITS-2];
              tx_shift    <= {tx_shift[SPI_BITS-3:0], 1'b0};
              state       <= ST_LOW;
            end
          end
        end
        ST_TEARDOWN: begin
          if (phase_done) begin
            hw_spi_ss <= 1'b1;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (phase_done) begin
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: a behavioural mode-0 slave plus scoreboard.
module tb_spi_master;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       hw_spi_clk;
  logic       hw_spi_ss;
  logic       hw_spi_mosi;
  logic       hw_spi_miso;

  spi_master #(.CLK_DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .hw_spi_clk (hw_spi_clk),
    .hw_spi_ss  (hw_spi_ss),
    .hw_spi_mosi(hw_spi_mosi),
    .hw_spi_miso(hw_spi_miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard queues filled at accept time.
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_mosi_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural mode-0 slave: shifts MISO on falling SCLK, captures MOSI on rising SCLK.
  logic       loopback = 1'b0;
  logic       sl_miso = 1'b0;
  logic [7:0] sl_cur = '0;
  logic [7:0] sl_cap = '0;
  int         sl_bit = 0;

  assign hw_spi_miso = loopback ? hw_spi_mosi : sl_miso;

  always @(negedge hw_spi_clk) begin
    if (!hw_spi_ss && sl_bit > 0) sl_miso = sl_cur[7 - sl_bit];
  end

  always @(posedge hw_spi_clk) begin
    if (!hw_spi_ss) begin
      sl_cap = {sl_cap[6:0], hw_spi_mosi};
      sl_bit++;
      if (sl_bit == 8) begin
        sl_bit = 0;
        check("mosi byte expected", 32'(exp_mosi_q.size() > 0), 1);
        if (exp_mosi_q.size() > 0) check("mosi byte", sl_cap, exp_mosi_q.pop_front());
      end
    end
  end

  // Output monitor: rx_valid scoreboard, SS rises, MOSI stability while SCLK high.
  int   rx_count = 0;
  int   ss_rises = 0;
  int   mosi_glitch = 0;
  logic prev_rxv = 1'b0;
  logic prev_sclk = 1'b0;
  logic prev_mosi = 1'b0;
  logic prev_ss = 1'b1;

  always @(negedge clk) begin
    if (rst_n && rx_valid) begin
      rx_count++;
      check("rx_valid single-cycle", 32'(prev_rxv), 0);
      check("rx expected", 32'(exp_rx_q.size() > 0), 1);
      if (exp_rx_q.size() > 0) check("rx_data", rx_data, exp_rx_q.pop_front());
    end
    if (rst_n && prev_sclk && hw_spi_clk && (hw_spi_mosi !== prev_mosi)) mosi_glitch++;
    if (!prev_ss && hw_spi_ss) ss_rises++;
    prev_rxv  = rx_valid;
    prev_sclk = hw_spi_clk;
    prev_mosi = hw_spi_mosi;
    prev_ss   = hw_spi_ss;
  end

  // Issue one byte; with garbage set, tx_valid stays high and tx_data/tx_last churn until ready.
  int acc_cyc = 0;
  task automatic send(input logic [7:0] d, input logic last, input logic [7:0] sl, input bit garbage);
    int budget = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = garbage ? 8'($urandom) : d;
    tx_last  = garbage ? 1'($urandom) : last;
    while (!tx_ready && budget < 4000) begin
      @(negedge clk);
      if (garbage) begin
        tx_data = 8'($urandom);
        tx_last = 1'($urandom);
      end
      budget++;
    end
    check("accept within budget", 32'(tx_ready), 1);
    tx_data = d;
    tx_last = last;
    exp_mosi_q.push_back(d);
    exp_rx_q.push_back(loopback ? d : sl);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    sl_cur   = sl;
    sl_bit   = 0;
    sl_miso  = sl[7];
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while ((busy || !tx_ready) && budget < 4000);
    check("idle reached", 32'(busy), 0);
  endtask

  task automatic wait_rx(input int base);
    int budget = 0;
    while (rx_count == base && budget < 4000) begin
      @(negedge clk);
      budget++;
    end
    check("rx_valid seen", 32'(rx_count - base), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   t;
    int   c0;
    int   s0;
    int   hi_cnt;
    int   ss_cnt;
    bit   open;
    logic l;

    repeat (3) @(negedge clk);
    // Reset values
    check("reset ss", 32'(hw_spi_ss), 1);
    check("reset sclk", 32'(hw_spi_clk), 0);
    check("reset mosi", 32'(hw_spi_mosi), 0);
    check("reset rx_data", 32'(rx_data), 0);
    check("reset rx_valid", 32'(rx_valid), 0);
    check("reset busy", 32'(busy), 0);
    check("reset tx_ready", 32'(tx_ready), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single-byte 0xA5 timing from the accept edge
    send(8'hA5, 1'b1, 8'($urandom), 1'b0);
    check("ss low after accept", 32'(hw_spi_ss), 0);
    check("mosi bit7 after accept", 32'(hw_spi_mosi), 1);
    check("busy after accept", 32'(busy), 1);
    t = 0;
    while (!hw_spi_clk && t < 1000) begin @(negedge clk); t++; end
    check("first sclk rise cycle", 32'(cyc - acc_cyc), 32'(DIV));
    t = 0;
    while (!rx_valid && t < 1000) begin @(negedge clk); t++; end
    check("rx_valid cycle", 32'(cyc - acc_cyc), 32'(16 * DIV));
    check("sclk low at rx_valid", 32'(hw_spi_clk), 0);
    t = 0;
    while (!hw_spi_ss && t < 1000) begin @(negedge clk); t++; end
    check("ss high cycle", 32'(cyc - acc_cyc), 32'(17 * DIV));
    check("mosi idle after frame", 32'(hw_spi_mosi), 0);
    t = 0;
    while (!tx_ready && t < 1000) begin @(negedge clk); t++; end
    check("tx_ready cycle", 32'(cyc - acc_cyc), 32'(18 * DIV));

    // Loopback 0x3C
    loopback = 1'b1;
    c0 = rx_count;
    send(8'h3C, 1'b1, 8'h00, 1'b0);
    wait_idle();
    check("loopback rx count", 32'(rx_count - c0), 1);
    check("loopback rx_data", 32'(rx_data), 32'h3C);
    loopback = 1'b0;

    // Three-byte frame: a single SS release
    s0 = ss_rises;
    c0 = rx_count;
    send(8'h01, 1'b0, 8'($urandom), 1'b0);
    send(8'h02, 1'b0, 8'($urandom), 1'b0);
    send(8'h03, 1'b1, 8'($urandom), 1'b0);
    wait_idle();
    check("frame ss rises", 32'(ss_rises - s0), 1);
    check("frame rx count", 32'(rx_count - c0), 3);

    // Producer stalls 500 cycles in HOLD
    c0 = rx_count;
    send(8'h5A, 1'b0, 8'($urandom), 1'b0);
    wait_rx(c0);
    hi_cnt = 0;
    ss_cnt = 0;
    repeat (500) begin
      @(negedge clk);
      if (hw_spi_clk) hi_cnt++;
      if (hw_spi_ss) ss_cnt++;
    end
    check("hold sclk high cycles", 32'(hi_cnt), 0);
    check("hold ss high cycles", 32'(ss_cnt), 0);
    check("hold tx_ready", 32'(tx_ready), 1);
    send(8'hC3, 1'b1, 8'($urandom), 1'b0);
    wait_idle();

    // Reset at cycle 100 of a transfer
    send(8'($urandom), 1'b1, 8'($urandom), 1'b0);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset ss", 32'(hw_spi_ss), 1);
    check("async reset sclk", 32'(hw_spi_clk), 0);
    exp_rx_q.delete();
    exp_mosi_q.delete();
    c0 = rx_count;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    check("no rx after reset", 32'(rx_count - c0), 0);
    send(8'hFF, 1'b1, 8'($urandom), 1'b0);
    wait_idle();
    check("post-reset rx count", 32'(rx_count - c0), 1);

    // tx_valid held high with churning data during HIGH/LOW
    send(8'h96, 1'b0, 8'($urandom), 1'b0);
    send(8'h69, 1'b1, 8'($urandom), 1'b1);
    wait_idle();

    // Randomised frames
    open = 1'b0;
    for (int i = 0; i < 25; i++) begin
      l = (($urandom % 3) == 0) || (i == 24);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send(8'($urandom), l, 8'($urandom), 1'($urandom));
      open = !l;
    end
    if (open) send(8'($urandom), 1'b1, 8'($urandom), 1'b0);
    wait_idle();

    check("rx queue drained", 32'(exp_rx_q.size()), 0);
    check("mosi queue drained", 32'(exp_mosi_q.size()), 0);
    check("mosi stable while sclk high", 32'(mosi_glitch), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
